// File: rtl/mem_stage_if.sv
// Data-memory bus between the RV32 memory stage (master) and data memory (slave).
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory stage: load/store sequencing, byte lanes and writeback of ALU or load results.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of issuing them.
module mem_stage (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_alu_result,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic [4:0]        ex_rd,
   input  logic [31:0]       ex_store_data,
   input  logic [2:0]        ex_funct3,
   mem_stage_if.master       dmem,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              misalign
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   function automatic size_t size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return SZ_B;
         3'b001, 3'b101: return SZ_H;
         default:        return SZ_W;
      endcase
   endfunction

   state_t      state, state_d;
   size_t       ex_size, size_q;
   logic        unsigned_q, is_load_q;
   logic [1:0]  addr_lo_q;
   logic [4:0]  rd_q;

   logic        accept, mem_op, misaligned;
   logic [3:0]  ex_be;
   logic [31:0] ex_wdata;
   logic [1:0]  shift;
   logic [31:0] lane, load_data;

   logic        req_we_q;
   logic [31:0] req_addr_q, req_wdata_q;
   logic [3:0]  req_be_q;

   assign mem_op  = ex_mem_read || ex_mem_write;
   assign ex_size = size_of(ex_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      case (ex_size)
         SZ_H:    misaligned = mem_op && ex_alu_result[0];
         SZ_W:    misaligned = mem_op && (ex_alu_result[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state;
      ex_ready = (state == ST_IDLE);
      accept   = ex_valid && (state == ST_IDLE);
      case (state)
         ST_IDLE: if (accept && mem_op && !misaligned) state_d = ST_REQ;
         ST_REQ:  if (dmem.dmem_gnt) state_d = is_load_q ? ST_WAIT : ST_IDLE;
         ST_WAIT: if (dmem.dmem_rvalid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Store lane formatting is derived straight from the execute inputs at accept time.
   always_comb begin
      ex_be    = 4'b1111;
      ex_wdata = ex_store_data;
      case (ex_size)
         SZ_B: begin
            ex_be    = 4'b0001 << ex_alu_result[1:0];
            ex_wdata = {4{ex_store_data[7:0]}};
         end
         SZ_H: begin
            ex_be    = 4'b0011 << {ex_alu_result[1], 1'b0};
            ex_wdata = {2{ex_store_data[15:0]}};
         end
         default: begin
            ex_be    = 4'b1111;
            ex_wdata = ex_store_data;
         end
      endcase
   end

   always_comb begin
      shift = 2'd0;
      case (size_q)
         SZ_B:    shift = addr_lo_q;
         SZ_H:    shift = {addr_lo_q[1], 1'b0};
         default: shift = 2'd0;
      endcase
      lane      = dmem.dmem_rdata >> {shift, 3'b000};
      load_data = lane;
      case (size_q)
         SZ_B: load_data = unsigned_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         SZ_H: load_data = unsigned_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_data = lane;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         size_q      <= SZ_W;
         unsigned_q  <= 1'b0;
         is_load_q   <= 1'b0;
         addr_lo_q   <= 2'b00;
         rd_q        <= 5'd0;
         req_we_q    <= 1'b0;
         req_addr_q  <= 32'h0;
         req_wdata_q <= 32'h0;
         req_be_q    <= 4'h0;
         wb_valid    <= 1'b0;
         wb_we       <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= 32'h0;
         misalign    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         misalign <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  size_q     <= ex_size;
                  unsigned_q <= ex_funct3[2];
                  is_load_q  <= ex_mem_read;
                  addr_lo_q  <= ex_alu_result[1:0];
                  rd_q       <= ex_rd;
                  if (!mem_op) begin
                     wb_valid <= 1'b1;
                     wb_we    <= ex_reg_write && (ex_rd != 5'd0);
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_alu_result;
                  end else if (misaligned) begin
                     wb_valid <= 1'b1;
                     misalign <= 1'b1;
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_alu_result;
                  end else begin
                     req_we_q    <= !ex_mem_read;
                     req_addr_q  <= {ex_alu_result[31:2], 2'b00};
                     req_be_q    <= ex_be;
                     req_wdata_q <= ex_mem_read ? 32'h0 : ex_wdata;
                  end
               end
            end
            ST_REQ: begin
               if (dmem.dmem_gnt) begin
                  req_we_q <= 1'b0;
                  if (!is_load_q) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= rd_q;
                     wb_data  <= 32'h0;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem.dmem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_we    <= (rd_q != 5'd0);
                  wb_rd    <= rd_q;
                  wb_data  <= load_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem.dmem_req   = (state == ST_REQ);
   assign dmem.dmem_we    = req_we_q;
   assign dmem.dmem_addr  = req_addr_q;
   assign dmem.dmem_wdata = req_wdata_q;
   assign dmem.dmem_be    = req_be_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue and popped on wb_valid.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_alu_result, ex_store_data;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        wb_valid, wb_we, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_stage_if dmem ();

   mem_stage dut (
      .clk(clk), .resetn(resetn),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
      .dmem(dmem.master),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk_data;
      logic        mis;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   wb_exp_t mon_e;
   int checks   = 0;
   int failures = 0;

   function automatic wb_exp_t mk(input logic we, input logic [4:0] rd,
                                  input logic [31:0] data, input logic chk, input logic mis);
      wb_exp_t e;
      e.we = we; e.rd = rd; e.data = data; e.chk_data = chk; e.mis = mis;
      return e;
   endfunction

   // Scoreboard monitor: every writeback pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && wb_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got we=%b rd=%0d data=%h mis=%b, expected none",
                     wb_we, wb_rd, wb_data, misalign);
         end else begin
            mon_e = exp_q.pop_front();
            if (wb_we !== mon_e.we || wb_rd !== mon_e.rd || misalign !== mon_e.mis ||
                (mon_e.chk_data && wb_data !== mon_e.data)) begin
               failures++;
               $display("FAIL wb_result: got we=%b rd=%0d data=%h mis=%b, expected we=%b rd=%0d data=%h mis=%b",
                        wb_we, wb_rd, wb_data, misalign, mon_e.we, mon_e.rd, mon_e.data, mon_e.mis);
            end
         end
      end else if (resetn === 1'b1 && misalign === 1'b1) begin
         checks++;
         failures++;
         $display("FAIL misalign_without_wb: got misalign=1 wb_valid=%b, expected misalign only with wb_valid",
                  wb_valid);
      end
   end

   task automatic drive_op(input logic rd_f, input logic wr_f, input logic rw_f,
                           input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] rd);
      ex_valid      = 1'b1;
      ex_mem_read   = rd_f;
      ex_mem_write  = wr_f;
      ex_reg_write  = rw_f;
      ex_funct3     = f3;
      ex_alu_result = alu;
      ex_store_data = sd;
      ex_rd         = rd;
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   // Memory responder: holds gnt low for gnt_delay cycles, then returns load data after rv_delay.
   task automatic serve_mem(input int gnt_delay, input logic is_load, input int rv_delay,
                            input logic [31:0] rdata, input logic [31:0] e_addr,
                            input logic [3:0] e_be, input logic [31:0] e_wdata);
      for (int i = 0; i <= gnt_delay; i++) begin
         checks++;
         if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== e_addr || dmem.dmem_we !== !is_load ||
             dmem.dmem_be !== e_be || (!is_load && dmem.dmem_wdata !== e_wdata) || ex_ready !== 1'b0) begin
            failures++;
            $display("FAIL mem_request: got req=%b addr=%h we=%b be=%b wdata=%h ready=%b, expected req=1 addr=%h we=%b be=%b wdata=%h ready=0",
                     dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we, dmem.dmem_be, dmem.dmem_wdata,
                     ex_ready, e_addr, !is_load, e_be, e_wdata);
         end
         if (i == gnt_delay) dmem.dmem_gnt = 1'b1;
         @(negedge clk);
      end
      dmem.dmem_gnt = 1'b0;
      if (is_load) begin
         for (int j = 0; j < rv_delay; j++) begin
            checks++;
            if (dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
               failures++;
               $display("FAIL load_wait: got req=%b wb_valid=%b, expected 0 0", dmem.dmem_req, wb_valid);
            end
            @(negedge clk);
         end
         dmem.dmem_rdata  = rdata;
         dmem.dmem_rvalid = 1'b1;
         @(negedge clk);
         dmem.dmem_rvalid = 1'b0;
         dmem.dmem_rdata  = $urandom;
      end
      checks++;
      if (dmem.dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b1) begin
         failures++;
         $display("FAIL mem_done: got req=%b ready=%b wb_valid=%b, expected 0 1 1",
                  dmem.dmem_req, ex_ready, wb_valid);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({ex_ready, dmem.dmem_req, dmem.dmem_we, dmem.dmem_be, dmem.dmem_addr, dmem.dmem_wdata,
           wb_valid, wb_we, wb_rd, wb_data, misalign} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
           1'b0, 1'b0, 5'd0, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: got ready=%b req=%b we=%b be=%b addr=%h wdata=%h wbv=%b wbwe=%b rd=%0d data=%h mis=%b, expected ready=1 rest 0",
                  ex_ready, dmem.dmem_req, dmem.dmem_we, dmem.dmem_be, dmem.dmem_addr,
                  dmem.dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, misalign);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (ex_ready !== 1'b1 || dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got ready=%b req=%b wb_valid=%b, expected 1 0 0",
                  ex_ready, dmem.dmem_req, wb_valid);
      end
   endtask

   task automatic test_alu;
      logic [31:0] alu [4] = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0077};
      logic [4:0]  rd  [4] = '{5'd5, 5'd31, 5'd0, 5'd2};
      logic        rw  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic        we  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(we[i], rd[i], alu[i], 1'b1, 1'b0));
         drive_op(1'b0, 1'b0, rw[i], 3'b010, alu[i], 32'h0, rd[i]);
         checks++;
         if (wb_valid !== 1'b1 || ex_ready !== 1'b1 || dmem.dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_latency[%0d]: got wb_valid=%b ready=%b req=%b, expected 1 1 0",
                     i, wb_valid, ex_ready, dmem.dmem_req);
         end
         @(negedge clk);
         checks++;
         if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_pulse[%0d]: got wb_valid=%b wb_we=%b, expected 0 0", i, wb_valid, wb_we);
         end
      end
   endtask

   task automatic test_store;
      logic [31:0] addr [5] = '{32'h103, 32'h202, 32'h204, 32'h200, 32'h200};
      logic [31:0] sd   [5] = '{32'hAB, 32'h1234ABCD, 32'hCAFEF00D, 32'h1FF, 32'h00005A5A};
      logic [2:0]  f3   [5] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
      logic [3:0]  be   [5] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001, 4'b0011};
      logic [31:0] wd   [5] = '{32'hABABABAB, 32'hABCDABCD, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h5A5A5A5A};
      logic [31:0] a;
      for (int i = 0; i < 5; i++) begin
         a = addr[i];
         exp_q.push_back(mk(1'b0, 5'd1 + 5'(i), 32'h0, 1'b0, 1'b0));
         drive_op(1'b0, 1'b1, 1'b0, f3[i], a, sd[i], 5'd1 + 5'(i));
         serve_mem((i == 0) ? 2 : i % 3, 1'b0, 0, 32'h0, {a[31:2], 2'b00}, be[i], wd[i]);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic [3:0]  be;
      logic        we;
      logic [31:0] data;
   } ld_vec_t;

   task automatic test_load;
      ld_vec_t lv [9];
      logic [31:0] a;
      lv[0] = '{1'b0, 3'b000, 32'h102, 32'h0080FF00, 5'd3,  4'b0100, 1'b1, 32'hFFFFFF80};
      lv[1] = '{1'b0, 3'b100, 32'h102, 32'h0080FF00, 5'd4,  4'b0100, 1'b1, 32'h00000080};
      lv[2] = '{1'b0, 3'b001, 32'h202, 32'h80001234, 5'd6,  4'b1100, 1'b1, 32'hFFFF8000};
      lv[3] = '{1'b0, 3'b101, 32'h202, 32'h80001234, 5'd6,  4'b1100, 1'b1, 32'h00008000};
      lv[4] = '{1'b0, 3'b010, 32'h300, 32'hDEADBEEF, 5'd7,  4'b1111, 1'b1, 32'hDEADBEEF};
      lv[5] = '{1'b0, 3'b011, 32'h304, 32'h01234567, 5'd8,  4'b1111, 1'b1, 32'h01234567};
      lv[6] = '{1'b0, 3'b000, 32'h001, 32'h00007F00, 5'd9,  4'b0010, 1'b1, 32'h0000007F};
      lv[7] = '{1'b0, 3'b010, 32'h308, 32'h13579BDF, 5'd0,  4'b1111, 1'b0, 32'h13579BDF};
      lv[8] = '{1'b1, 3'b100, 32'h003, 32'hC5000000, 5'd11, 4'b1000, 1'b1, 32'h000000C5};
      for (int i = 0; i < 9; i++) begin
         a = lv[i].addr;
         exp_q.push_back(mk(lv[i].we, lv[i].rd, lv[i].data, 1'b1, 1'b0));
         drive_op(1'b1, lv[i].wr, 1'b1, lv[i].f3, a, 32'hFFFF_FFFF, lv[i].rd);
         serve_mem(i % 3, 1'b1, i % 2, lv[i].rdata, {a[31:2], 2'b00}, lv[i].be, 32'h0);
      end
   endtask

   task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
      logic [31:0] addr [4] = '{32'h101, 32'h102, 32'h103, 32'h205};
      logic [2:0]  f3   [4] = '{3'b001, 3'b010, 3'b010, 3'b101};
      logic        wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(1'b0, 5'd12, 32'h0, 1'b0, 1'b1));
         drive_op(!wr[i], wr[i], 1'b1, f3[i], addr[i], 32'h1234, 5'd12);
         checks++;
         if (dmem.dmem_req !== 1'b0 || misalign !== 1'b1 || ex_ready !== 1'b1 || wb_we !== 1'b0) begin
            failures++;
            $display("FAIL misalign_trap[%0d]: got req=%b mis=%b ready=%b wb_we=%b, expected 0 1 1 0",
                     i, dmem.dmem_req, misalign, ex_ready, wb_we);
         end
         @(negedge clk);
         checks++;
         if (dmem.dmem_req !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse[%0d]: got req=%b mis=%b, expected 0 0",
                     i, dmem.dmem_req, misalign);
         end
      end
`else
      exp_q.push_back(mk(1'b1, 5'd13, 32'hFFFF8765, 1'b1, 1'b0));
      drive_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 5'd13);
      serve_mem(1, 1'b1, 1, 32'h12348765, 32'h100, 4'b0011, 32'h0);
      exp_q.push_back(mk(1'b1, 5'd14, 32'hA5A50001, 1'b1, 1'b0));
      drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd14);
      serve_mem(0, 1'b1, 0, 32'hA5A50001, 32'h100, 4'b1111, 32'h0);
      exp_q.push_back(mk(1'b0, 5'd15, 32'h0, 1'b0, 1'b0));
      drive_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h103, 32'h0000BEEF, 5'd15);
      serve_mem(0, 1'b0, 0, 32'h0, 32'h100, 4'b1100, 32'hBEEFBEEF);
`endif
   endtask

   task automatic test_reset_mid;
      drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 5'd10);
      dmem.dmem_gnt = 1'b1;
      @(negedge clk);
      dmem.dmem_gnt = 1'b0;
      checks++;
      if (dmem.dmem_req !== 1'b0 || ex_ready !== 1'b0) begin
         failures++;
         $display("FAIL wait_state: got req=%b ready=%b, expected 0 0", dmem.dmem_req, ex_ready);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1 ||
          dmem.dmem_addr !== 32'h0 || dmem.dmem_be !== 4'h0) begin
         failures++;
         $display("FAIL async_reset: got req=%b wb_valid=%b ready=%b addr=%h be=%b, expected 0 0 1 0 0",
                  dmem.dmem_req, wb_valid, ex_ready, dmem.dmem_addr, dmem.dmem_be);
      end
      @(negedge clk);
      resetn = 1'b1;
      dmem.dmem_rvalid = 1'b1;
      dmem.dmem_rdata  = 32'hBADD_F00D;
      dmem.dmem_gnt    = 1'b1;
      @(negedge clk);
      dmem.dmem_rvalid = 1'b0;
      dmem.dmem_gnt    = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || dmem.dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL late_response: got wb_valid=%b req=%b ready=%b, expected 0 0 1",
                  wb_valid, dmem.dmem_req, ex_ready);
      end
      exp_q.push_back(mk(1'b1, 5'd20, 32'h0000_4242, 1'b1, 1'b0));
      drive_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_4242, 32'h0, 5'd20);
      checks++;
      if (wb_valid !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_alu: got wb_valid=%b, expected 1", wb_valid);
      end
   endtask

   task automatic test_back_to_back;
      ex_valid = 1'b1;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
      ex_funct3 = 3'b000; ex_store_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         ex_alu_result = 32'h1000 + 32'(i);
         ex_rd         = 5'd21 + 5'(i);
         exp_q.push_back(mk(1'b1, 5'd21 + 5'(i), 32'h1000 + 32'(i), 1'b1, 1'b0));
         @(negedge clk);
         checks++;
         if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_alu[%0d]: got wb_valid=%b ready=%b, expected 1 1", i, wb_valid, ex_ready);
         end
      end
      ex_mem_write = 1'b1; ex_reg_write = 1'b0; ex_funct3 = 3'b010;
      ex_alu_result = 32'h500; ex_store_data = 32'h11; ex_rd = 5'd1;
      exp_q.push_back(mk(1'b0, 5'd1, 32'h0, 1'b0, 1'b0));
      @(negedge clk);
      ex_mem_write = 1'b0; ex_reg_write = 1'b1;
      ex_alu_result = 32'h99; ex_rd = 5'd12;
      exp_q.push_back(mk(1'b1, 5'd12, 32'h99, 1'b1, 1'b0));
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ex_ready !== 1'b0 || dmem.dmem_req !== 1'b1 || dmem.dmem_wdata !== 32'h11) begin
            failures++;
            $display("FAIL b2b_stall[%0d]: got ready=%b req=%b wdata=%h, expected 0 1 00000011",
                     i, ex_ready, dmem.dmem_req, dmem.dmem_wdata);
         end
         @(negedge clk);
      end
      dmem.dmem_gnt = 1'b1;
      @(negedge clk);
      dmem.dmem_gnt = 1'b0;
      checks++;
      if (ex_ready !== 1'b1 || wb_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_resume: got ready=%b wb_valid=%b, expected 1 1", ex_ready, wb_valid);
      end
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
      ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0; ex_funct3 = 3'b000;
      dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
      #12;
      test_reset;
      test_alu;
      test_store;
      test_load;
      test_misalign;
      test_reset_mid;
      test_back_to_back;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending writebacks, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed (RV32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute-stage result valid this cycle.
REQ-005 ex_ready  output  1  stage can accept a new op; high only in IDLE.
REQ-006 ex_alu_result  input  32  ALU result, or effective address for load/store.
REQ-007 ex_mem_read / ex_mem_write / ex_reg_write  input  1 each  op class from execute.
REQ-008 ex_rd  input  5  destination register index.
REQ-009 ex_store_data  input  32  rs2 value for stores.
REQ-010 ex_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 dmem_req / dmem_we  output  1 each  memory request; write when dmem_we=1.
REQ-012 dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dmem_wdata  output  32, dmem_be  output  4  store data and byte enables.
REQ-014 dmem_gnt  input  1  request accepted this cycle.
REQ-015 dmem_rvalid  input  1, dmem_rdata  input  32  load data return.
REQ-016 wb_valid  output  1, wb_we  output  1, wb_rd  output  5, wb_data  output  32  writeback result.
REQ-017 misalign  output  1  misaligned-access exception pulse.

Function
REQ-018 FSM states: IDLE, REQ, WAIT; ex_ready = (state==IDLE).
REQ-019 Accept on ex_valid&&ex_ready; capture address, store data, funct3, rd and op flags into registers.
REQ-020 Non-memory op accepted in cycle N: wb_valid=1 in N+1 for one cycle, wb_data=ex_alu_result, wb_we=ex_reg_write; FSM stays IDLE.
REQ-021 Memory op accepted: IDLE->REQ; dmem_req held high with stable addr/we/wdata/be until the cycle dmem_gnt=1.
REQ-022 Store, gnt in cycle M: REQ->IDLE; wb_valid pulse in M+1 with wb_we=0.
REQ-023 Load, gnt in cycle M: REQ->WAIT; on dmem_rvalid in cycle K>M: WAIT->IDLE, wb_valid pulse in K+1 with wb_we=1 and extended data.
REQ-024 dmem_rvalid outside WAIT is ignored; memory never returns rvalid in the gnt cycle.
REQ-025 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-026 Store data: B {4{sd[7:0]}}; H {2{sd[15:0]}}; W sd.
REQ-027 Load extract: lane = rdata>>(8*addr[1:0]); B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-028 wb_rd=0 forces wb_we=0.
REQ-029 Unlisted funct3 on a memory op is treated as W.
REQ-030 wb_valid, wb_we and misalign are single-cycle pulses; no backpressure from writeback.
REQ-031 ex_mem_read and ex_mem_write both high: treat as load.

Reset
REQ-032 resetn low: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, misalign=0, all taking effect immediately.
REQ-033 Reset mid-transaction abandons the op; late gnt/rvalid after reset release is ignored in IDLE.

Configuration
REQ-034 MEM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 issues no dmem_req; misalign=1 and wb_valid=1 with wb_we=0 in N+1; FSM stays IDLE.
REQ-035 MEM_MISALIGN_TRAP_EN undefined: misalign tied 0; H uses addr[1] only, W ignores addr[1:0]; access proceeds normally.

Verification
REQ-036 ADD result 0x1234, rd=5, reg_write=1 -> wb_valid next cycle, wb_data=0x1234, wb_we=1, wb_rd=5.
REQ-037 SB addr 0x103, sd 0xAB, gnt after 2 cycles -> dmem_addr 0x100, be 4'b1000, wdata 0xABABABAB held 3 cycles; wb_valid with wb_we=0.
REQ-038 LB addr 0x102, rdata 0x0080FF00 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LH addr 0x101 -> with macro: misalign=1, no dmem_req; without: be 4'b0011, data from low half.
REQ-040 resetn low while in WAIT -> dmem_req and wb_valid 0 immediately; later rvalid produces no wb_valid; ex_ready=1.
